// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: signed decimal entry, operator/equals sequencing and a
// start/done handshake to an external arithmetic unit, with chaining, repeat-equals and error handling.
module calc_seq_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DIGIT_MAX = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             key_valid,
  input  logic [3:0]       key_digit,
  input  logic             neg_valid,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic             eq_valid,
  input  logic             clr_valid,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic             busy,
  output logic             complete,
  output logic             error,
  output logic [WIDTH-1:0] display_output
);
  localparam int CW = $clog2(DIGIT_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH+3:0] MAX_MAG = {5'b00000, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0, S_ENTER_B = 3'd1, S_ISSUE = 3'd2,
    S_WAIT    = 3'd3, S_SHOW    = 3'd4, S_ERR   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    A_NONE = 3'd0, A_CLR = 3'd1, A_EQ = 3'd2, A_OP = 3'd3, A_NEG = 3'd4, A_KEY = 3'd5
  } act_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mag_q, mag_d, a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  logic              sign_q, sign_d;
  logic [CW-1:0]     dcnt_q, dcnt_d;
  logic [1:0]        op_q, op_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              start_q, start_d, cmpl_q, cmpl_d, busy_q, busy_d, err_q, err_d;

  act_t              act_s;
  logic              key_ok_s, key_acc_s, entry_nxt_s;
  logic [WIDTH+3:0]  new_mag_s;
  logic [WIDTH-1:0]  entry_val_s;

  // One strobe per cycle, highest priority wins.
  always_comb begin
    if (clr_valid)      act_s = A_CLR;
    else if (eq_valid)  act_s = A_EQ;
    else if (op_valid)  act_s = A_OP;
    else if (neg_valid) act_s = A_NEG;
    else if (key_valid) act_s = A_KEY;
    else                act_s = A_NONE;
  end

  assign key_ok_s    = (key_digit <= 4'd9);
  assign new_mag_s   = {4'b0000, mag_q} * (WIDTH+4)'(10) + (WIDTH+4)'(key_digit);
  assign key_acc_s   = key_ok_s && (dcnt_q < CW'(DIGIT_MAX)) && (new_mag_s <= MAX_MAG);
  assign entry_val_s = sign_q ? (-mag_q) : mag_q;

  // Next-state and next-register computation.
  always_comb begin
    state_d = state_q; mag_d = mag_q; sign_d = sign_q; dcnt_d = dcnt_q;
    a_d = a_q; b_d = b_q; op_d = op_q; res_d = res_q; disp_d = disp_q; tmo_d = tmo_q;
    start_d = 1'b0; cmpl_d = 1'b0; busy_d = 1'b0; err_d = 1'b0;
    if (act_s == A_CLR) begin
      state_d = S_ENTER_A; mag_d = '0; sign_d = 1'b0; dcnt_d = '0;
      a_d = '0; b_d = '0; op_d = 2'b00; res_d = '0; disp_d = '0; tmo_d = '0;
    end else begin
      case (state_q)
        S_ENTER_A, S_ENTER_B: begin
          case (act_s)
            A_EQ: begin
              if (state_q == S_ENTER_B) begin
                b_d = entry_val_s; state_d = S_ISSUE;
              end else begin
                state_d = S_ENTER_A;
              end
            end
            A_OP: begin
              if (op_code == 2'b11) begin
                op_d = op_q;
              end else if (state_q == S_ENTER_A) begin
                a_d = entry_val_s; op_d = op_code;
                mag_d = '0; sign_d = 1'b0; dcnt_d = '0; state_d = S_ENTER_B;
              end else begin
                op_d = op_code;
              end
            end
            A_NEG: sign_d = ~sign_q;
            A_KEY: begin
              if (key_acc_s) begin
                mag_d = new_mag_s[WIDTH-1:0]; dcnt_d = dcnt_q + CW'(1);
              end else begin
                mag_d = mag_q;
              end
            end
            default: state_d = state_q;
          endcase
        end
        S_ISSUE: begin
          state_d = S_WAIT; tmo_d = '0;
        end
        S_WAIT: begin
          if (alu_done) begin
            if (alu_ovf) begin
              state_d = S_ERR;
            end else begin
              res_d = alu_result; disp_d = alu_result; cmpl_d = 1'b1; state_d = S_SHOW;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_SHOW: begin
          case (act_s)
            A_OP: begin
              if (op_code != 2'b11) begin
                a_d = res_q; op_d = op_code;
                mag_d = '0; sign_d = 1'b0; dcnt_d = '0; state_d = S_ENTER_B;
              end else begin
                op_d = op_q;
              end
            end
            A_EQ: begin
              a_d = res_q; state_d = S_ISSUE;
            end
            A_KEY: begin
              if (key_ok_s) begin
                mag_d = WIDTH'(key_digit); sign_d = 1'b0; dcnt_d = CW'(1); state_d = S_ENTER_A;
              end else begin
                state_d = S_SHOW;
              end
            end
            default: state_d = state_q;
          endcase
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_ENTER_A;
      endcase
    end
    // Outputs are registered so they line up with the state they describe.
    start_d     = (state_d == S_ISSUE);
    busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT);
    err_d       = (state_d == S_ERR);
    entry_nxt_s = (state_d == S_ENTER_A) || (state_d == S_ENTER_B);
    disp_d      = entry_nxt_s ? (sign_d ? (-mag_d) : mag_d)
                              : ((state_d == S_ERR) ? {WIDTH{1'b0}} : disp_d);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_ENTER_A; mag_q <= '0; sign_q <= 1'b0; dcnt_q <= '0;
      a_q <= '0; b_q <= '0; op_q <= 2'b00; res_q <= '0; disp_q <= '0; tmo_q <= '0;
      start_q <= 1'b0; cmpl_q <= 1'b0; busy_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; mag_q <= mag_d; sign_q <= sign_d; dcnt_q <= dcnt_d;
      a_q <= a_d; b_q <= b_d; op_q <= op_d; res_q <= res_d; disp_q <= disp_d; tmo_q <= tmo_d;
      start_q <= start_d; cmpl_q <= cmpl_d; busy_q <= busy_d; err_q <= err_d;
    end
  end

  assign alu_start      = start_q;
  assign alu_op         = op_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign busy           = busy_q;
  assign complete       = cmpl_q;
  assign error          = err_q;
  assign display_output = disp_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed scenarios then random key/op/eq/clr traffic,
// checked against a calculator-level reference model with an in-bench arithmetic unit.
module tb_calc_seq_ctrl;
  localparam int TMO = 8;

  logic        clk = 1'b0, nRST = 1'b0;
  logic        key_valid = 1'b0, neg_valid = 1'b0, op_valid = 1'b0, eq_valid = 1'b0, clr_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic [1:0]  op_code = 2'd0;
  logic        alu_done = 1'b0, alu_ovf = 1'b0;
  logic [15:0] alu_result = 16'd0;
  logic        alu_start, busy, complete, error;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b, display_output;

  calc_seq_ctrl #(.WIDTH(16), .DIGIT_MAX(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .nRST(nRST), .key_valid(key_valid), .key_digit(key_digit),
    .neg_valid(neg_valid), .op_valid(op_valid), .op_code(op_code),
    .eq_valid(eq_valid), .clr_valid(clr_valid), .alu_start(alu_start),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .busy(busy),
    .complete(complete), .error(error), .display_output(display_output)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int start_cnt = 0, cmpl_cnt = 0;

  always @(posedge clk) begin
    if (alu_start) start_cnt <= start_cnt + 1;
    if (complete)  cmpl_cnt  <= cmpl_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Calculator-level reference model.
  localparam int M_A = 0, M_B = 1, M_SHOW = 3, M_ERR = 4;
  int m_mode, m_mag, m_sgn, m_nd, m_a, m_b, m_op, m_res, m_disp;

  function automatic logic [31:0] w16(input int v);
    return 32'(v) & 32'h0000_FFFF;
  endfunction

  function automatic int mval();
    return (m_sgn != 0) ? -m_mag : m_mag;
  endfunction

  task automatic model_reset();
    m_mode = M_A; m_mag = 0; m_sgn = 0; m_nd = 0;
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_disp = 0;
  endtask

  task automatic model_step(input int kind, input int val);
    case (kind)
      0: begin
        if (m_mode == M_A || m_mode == M_B) begin
          if (val <= 9 && m_nd < 5 && m_mag * 10 + val <= 32767) begin
            m_mag = m_mag * 10 + val; m_nd++;
          end
          m_disp = mval();
        end else if (m_mode == M_SHOW && val <= 9) begin
          m_mode = M_A; m_mag = val; m_sgn = 0; m_nd = 1; m_disp = val;
        end
      end
      1: if (m_mode == M_A || m_mode == M_B) begin m_sgn = 1 - m_sgn; m_disp = mval(); end
      2: if (val != 3) begin
        if (m_mode == M_A || m_mode == M_SHOW) begin
          m_a = (m_mode == M_A) ? mval() : m_res;
          m_op = val; m_mag = 0; m_sgn = 0; m_nd = 0; m_mode = M_B; m_disp = 0;
        end else if (m_mode == M_B) m_op = val;
      end
      4: model_reset();
      default: ;
    endcase
  endtask

  task automatic strobe(input int kind, input int val);
    case (kind)
      0: begin key_valid = 1'b1; key_digit = 4'(val); end
      1: neg_valid = 1'b1;
      2: begin op_valid = 1'b1; op_code = 2'(val); end
      3: eq_valid = 1'b1;
      default: clr_valid = 1'b1;
    endcase
    @(negedge clk);
    key_valid = 1'b0; neg_valid = 1'b0; op_valid = 1'b0; eq_valid = 1'b0; clr_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_disp"}, 32'(display_output), w16(m_disp));
    check_val({tag, "_err"},  32'(error), (m_mode == M_ERR) ? 32'd1 : 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_cmpl"}, 32'(complete), 32'd0);
  endtask

  task automatic act(input int kind, input int val);
    strobe(kind, val);
    model_step(kind, val);
    check_idle($sformatf("act%0d_%0d", kind, val));
  endtask

  // Equals: lat = WAIT cycles before done is presented; tmo = never answer; fovf = force overflow flag.
  task automatic do_eq(input int lat, input bit tmo, input bit fovf);
    int sc, cc, r;
    bit ovf;
    sc = start_cnt; cc = cmpl_cnt;
    if (m_mode != M_B && m_mode != M_SHOW) begin
      strobe(3, 0);
      check_idle("eq_ignored");
      return;
    end
    if (m_mode == M_B) m_b = mval(); else m_a = m_res;
    strobe(3, 0);
    check_val("issue_start", 32'(alu_start), 32'd1);
    check_val("issue_busy", 32'(busy), 32'd1);
    check_val("issue_a", 32'(alu_a), w16(m_a));
    check_val("issue_b", 32'(alu_b), w16(m_b));
    check_val("issue_op", 32'(alu_op), 32'(m_op));
    if (tmo) begin
      repeat (TMO) @(negedge clk);
      check_val("tmo_last_wait_err", 32'(error), 32'd0);
      check_val("tmo_last_wait_busy", 32'(busy), 32'd1);
      @(negedge clk);
      m_mode = M_ERR; m_disp = 0;
      check_idle("tmo_err");
      check_val("tmo_no_cmpl", 32'(cmpl_cnt - cc), 32'd0);
    end else begin
      case (m_op)
        0: r = m_a + m_b;
        1: r = m_a - m_b;
        default: r = m_a * m_b;
      endcase
      ovf = fovf || r > 32767 || r < -32768;
      @(negedge clk);
      check_val("wait_start_low", 32'(alu_start), 32'd0);
      repeat (lat - 1) @(negedge clk);
      check_val("wait_busy", 32'(busy), 32'd1);
      check_val("wait_a_hold", 32'(alu_a), w16(m_a));
      alu_done = 1'b1; alu_result = 16'(r); alu_ovf = ovf;
      @(negedge clk);
      alu_done = 1'b0; alu_ovf = 1'b0;
      if (ovf) begin
        m_mode = M_ERR; m_disp = 0;
        check_idle("ovf_err");
      end else begin
        m_mode = M_SHOW; m_res = r; m_disp = r;
        check_val("done_cmpl", 32'(complete), 32'd1);
        check_val("done_disp", 32'(display_output), w16(r));
        @(negedge clk);
        check_idle("show");
      end
      check_val("cmpl_count", 32'(cmpl_cnt - cc), ovf ? 32'd0 : 32'd1);
    end
    check_val("start_count", 32'(start_cnt - sc), 32'd1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_disp", 32'(display_output), 32'd0);
    check_val("rst_flags", {28'd0, alu_start, busy, complete, error}, 32'd0);
    check_val("rst_alu", {alu_op, alu_a[13:0], alu_b}, 32'd0);
    nRST = 1'b1;
    @(negedge clk);

    act(0, 1); act(0, 2); act(0, 3); act(2, 0); act(0, 4); act(0, 5);
    do_eq(3, 1'b0, 1'b0);
    check_val("t1_168", 32'(display_output), 32'd168);

    act(2, 2); act(0, 2); do_eq(2, 1'b0, 1'b0);
    check_val("t4_336", 32'(display_output), 32'd336);
    do_eq(1, 1'b0, 1'b0);
    check_val("t4_672", 32'(display_output), 32'd672);

    act(4, 0); act(0, 7); act(1, 0); act(2, 1); act(0, 9);
    do_eq(2, 1'b0, 1'b0);
    check_val("t2_fff0", 32'(display_output), 32'h0000_FFF0);

    act(4, 0); act(0, 3); act(0, 2); act(0, 7); act(0, 6); act(0, 7);
    check_val("t3_32767", 32'(display_output), 32'd32767);
    act(0, 1);
    act(4, 0); act(0, 3); act(0, 2); act(0, 7); act(0, 6); act(0, 8);
    check_val("t3_3276", 32'(display_output), 32'd3276);
    act(0, 12); act(3'd2, 3); act(3'd2, 0); act(0, 5);
    do_eq(8, 1'b0, 1'b0);
    act(0, 4); act(2, 0); act(0, 1);
    do_eq(1, 1'b1, 1'b0);
    act(0, 5); act(3'd2, 0);
    act(4, 0);
    check_val("t5_clr_err", 32'(error), 32'd0);
    act(0, 2); act(2, 0); act(0, 2);
    do_eq(2, 1'b0, 1'b1);
    check_val("t5_ovf_err", 32'(error), 32'd1);
    act(4, 0);

    act(0, 1); act(2, 0); act(0, 2);
    strobe(3, 0);
    @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    check_val("t6_rst_flags", {28'd0, alu_start, busy, complete, error}, 32'd0);
    check_val("t6_rst_data", {display_output, alu_a}, 32'd0);
    check_val("t6_rst_b_op", {14'd0, alu_op, alu_b}, 32'd0);
    model_reset();
    @(negedge clk);
    nRST = 1'b1;
    alu_done = 1'b1; alu_result = 16'd3;
    @(negedge clk);
    alu_done = 1'b0;
    check_idle("t6_late_done");

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      act(0, $urandom_range(0, 11));
      else if (r < 52) act(1, 0);
      else if (r < 66) act(2, $urandom_range(0, 3));
      else if (r < 90) do_eq($urandom_range(1, TMO), ($urandom_range(0, 19) == 0),
                             ($urandom_range(0, 19) == 0));
      else             act(4, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
